// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and widths for the I/D memory arbiter
package mem_arbiter_pkg;
  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_e;
  localparam logic M_I = 1'b0;
  localparam logic M_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational two-way picker between the I and D requests
module arb_pick import mem_arbiter_pkg::*; #(
  parameter bit          D_PRIORITY = 1'b1,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic       req_i_i,
  input  logic       req_d_i,
  input  logic       last_grant_i,
  input  logic [3:0] wait_cnt_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);
  logic tie_id;
  // Tie break: D wins unless I has waited MAX_WAIT grants, or alternate against the last winner
  always_comb begin
    tie_id        = D_PRIORITY ? ((wait_cnt_i == 4'(MAX_WAIT)) ? M_I : M_D) : ~last_grant_i;
    grant_valid_o = req_i_i | req_d_i;
    grant_id_o    = (req_i_i & req_d_i) ? tie_id : (req_d_i ? M_D : M_I);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache and the D-cache
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter bit          D_PRIORITY = 1'b1,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [MEM_ADDR_W-1:0] i_mem_addr,
  input  logic [MEM_DATA_W-1:0] i_mem_wdata,
  output logic                  i_mem_ready,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [MEM_ADDR_W-1:0] d_mem_addr,
  input  logic [MEM_DATA_W-1:0] d_mem_wdata,
  output logic                  d_mem_ready,
  input  logic [MEM_DATA_W-1:0] mem_rdata_in,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic [MEM_DATA_W-1:0] mem_rdata
);
  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       req_i, req_d, grant_valid, grant_id, gnt_i, gnt_d;

  assign req_i     = i_mem_read | i_mem_write;
  assign req_d     = d_mem_read | d_mem_write;
  assign mem_rdata = mem_rdata_in;

  arb_pick #(.D_PRIORITY(D_PRIORITY), .MAX_WAIT(MAX_WAIT)) u_pick (
    .req_i_i      (req_i),
    .req_d_i      (req_d),
    .last_grant_i (last_grant_q),
    .wait_cnt_i   (wait_cnt_q),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  // Registered grant, last winner and I starvation count
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= M_D;
      wait_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Arbitrate only from IDLE; a granted access runs to its ready pulse and is never aborted
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      ST_IDLE: if (grant_valid) begin
        state_d    = (grant_id == M_D) ? ST_GRANT_D : ST_GRANT_I;
        wait_cnt_d = (grant_id == M_I || !D_PRIORITY) ? 4'd0 :
                     (req_i && wait_cnt_q != 4'(MAX_WAIT)) ? wait_cnt_q + 4'd1 : wait_cnt_q;
      end
      ST_GRANT_I, ST_GRANT_D: if (mem_ready) begin
        state_d      = ST_IDLE;
        last_grant_d = (state_q == ST_GRANT_D) ? M_D : M_I;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Forward the owner's request to memory and steer the ready pulse back to the owner only
  always_comb begin
    gnt_i       = state_q == ST_GRANT_I;
    gnt_d       = state_q == ST_GRANT_D;
    mem_read    = gnt_i ? i_mem_read  : gnt_d & d_mem_read;
    mem_write   = gnt_i ? i_mem_write : gnt_d & d_mem_write;
    mem_addr    = gnt_i ? i_mem_addr  : gnt_d ? d_mem_addr  : '0;
    mem_wdata   = gnt_i ? i_mem_wdata : gnt_d ? d_mem_wdata : '0;
    i_mem_ready = gnt_i & mem_ready;
    d_mem_ready = gnt_d & mem_ready;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, grant-order sequence and random model check for both arbitration modes
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic proc_reset, i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_ready;
  logic [27:0] i_mem_addr, d_mem_addr;
  logic [127:0] i_mem_wdata, d_mem_wdata, mem_rdata_in;
  logic rr_ird, rr_drd, rr_mr, rr_mw, dp_ird, dp_drd, dp_mr, dp_mw;
  logic [27:0] rr_ma, dp_ma;
  logic [127:0] rr_mwd, rr_mrd, dp_mwd, dp_mrd;

  mem_arbiter #(.D_PRIORITY(1'b0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_mem_ready(rr_ird),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_ready(rr_drd),
    .mem_rdata_in(mem_rdata_in), .mem_ready(mem_ready), .mem_read(rr_mr), .mem_write(rr_mw),
    .mem_addr(rr_ma), .mem_wdata(rr_mwd), .mem_rdata(rr_mrd)
  );

  mem_arbiter #(.D_PRIORITY(1'b1), .MAX_WAIT(4)) dut_dp (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_mem_ready(dp_ird),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_ready(dp_drd),
    .mem_rdata_in(mem_rdata_in), .mem_ready(mem_ready), .mem_read(dp_mr), .mem_write(dp_mw),
    .mem_addr(dp_ma), .mem_wdata(dp_mwd), .mem_rdata(dp_mrd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, ir, dr, dw, rdy;
    logic [1:0] st;
    logic mr, mw, irdy, drdy;
  } vec_t;
  vec_t tbl[28];

  // Reference model: who owns the port (0 none, 1 I, 2 D), last winner (0 I, 1 D), D grants since I last won
  int own[2], last[2], streak[2];

  task automatic model_step(input int k);
    int win;
    if (proc_reset) begin
      own[k] = 0; last[k] = 1; streak[k] = 0;
    end else if (own[k] != 0) begin
      if (mem_ready) begin
        last[k] = own[k] - 1;
        own[k] = 0;
      end
    end else if ((i_mem_read | i_mem_write) || (d_mem_read | d_mem_write)) begin
      if ((i_mem_read | i_mem_write) && (d_mem_read | d_mem_write))
        win = (k == 1) ? ((streak[k] == 4) ? 0 : 1) : 1 - last[k];
      else
        win = (d_mem_read | d_mem_write) ? 1 : 0;
      own[k] = win + 1;
      if (win == 0) streak[k] = 0;
      else if (k == 1 && (i_mem_read | i_mem_write)) streak[k] = (streak[k] < 4) ? streak[k] + 1 : 4;
    end
  endtask

  function automatic logic [255:0] expv(input int o);
    if (o == 1) return {96'd0, i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata, mem_ready, 1'b0};
    if (o == 2) return {96'd0, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, 1'b0, mem_ready};
    return '0;
  endfunction

  task automatic zero_inputs();
    i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0; mem_ready = 0;
    i_mem_addr = 28'h0000010; d_mem_addr = 28'h0000020;
    i_mem_wdata = 128'h11112222333344445555666677778888;
    d_mem_wdata = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    mem_rdata_in = 128'hCAFEF00D0123456789ABCDEF55AA55AA;
  endtask

  initial begin
    string got;
    logic [1:0] st;
    logic [27:0] ea;
    logic [127:0] ew;
    zero_inputs();
    proc_reset = 1;
    repeat (2) @(posedge clk);
    tbl[0]  = '{0,1,0,0,0, 2'd0,0,0,0,0};
    tbl[1]  = '{0,1,0,0,0, 2'd1,1,0,0,0};
    tbl[2]  = '{0,1,0,0,0, 2'd1,1,0,0,0};
    tbl[3]  = '{0,1,0,0,0, 2'd1,1,0,0,0};
    tbl[4]  = '{0,1,0,0,1, 2'd1,1,0,1,0};
    tbl[5]  = '{0,0,0,0,0, 2'd0,0,0,0,0};
    tbl[6]  = '{0,0,0,0,1, 2'd0,0,0,0,0};
    tbl[7]  = '{0,0,0,0,0, 2'd0,0,0,0,0};
    tbl[8]  = '{1,1,0,1,0, 2'd0,0,0,0,0};
    tbl[9]  = '{0,1,0,1,0, 2'd0,0,0,0,0};
    tbl[10] = '{0,1,0,1,0, 2'd1,1,0,0,0};
    tbl[11] = '{0,1,0,1,1, 2'd1,1,0,1,0};
    tbl[12] = '{0,1,0,1,0, 2'd0,0,0,0,0};
    tbl[13] = '{0,1,0,1,0, 2'd2,0,1,0,0};
    tbl[14] = '{0,1,0,1,1, 2'd2,0,1,0,1};
    tbl[15] = '{0,1,0,1,0, 2'd0,0,0,0,0};
    tbl[16] = '{0,1,0,1,1, 2'd1,1,0,1,0};
    tbl[17] = '{0,1,0,1,0, 2'd0,0,0,0,0};
    tbl[18] = '{0,0,0,1,0, 2'd2,0,1,0,0};
    tbl[19] = '{1,0,0,1,0, 2'd2,0,1,0,0};
    tbl[20] = '{0,1,0,1,0, 2'd0,0,0,0,0};
    tbl[21] = '{0,1,0,1,0, 2'd1,1,0,0,0};
    tbl[22] = '{0,0,0,1,0, 2'd1,0,0,0,0};
    tbl[23] = '{0,0,0,1,1, 2'd1,0,0,1,0};
    tbl[24] = '{0,0,0,1,0, 2'd0,0,0,0,0};
    tbl[25] = '{0,0,0,1,0, 2'd2,0,1,0,0};
    tbl[26] = '{0,0,0,1,1, 2'd2,0,1,0,1};
    tbl[27] = '{0,0,0,0,0, 2'd0,0,0,0,0};
    for (int r = 0; r < 28; r++) begin
      @(negedge clk);
      proc_reset = tbl[r].rst; i_mem_read = tbl[r].ir; d_mem_read = tbl[r].dr;
      d_mem_write = tbl[r].dw; mem_ready = tbl[r].rdy;
      #1;
      ea = (tbl[r].st == 2'd1) ? i_mem_addr : (tbl[r].st == 2'd2) ? d_mem_addr : 28'd0;
      ew = (tbl[r].st == 2'd1) ? i_mem_wdata : (tbl[r].st == 2'd2) ? d_mem_wdata : 128'd0;
      chk($sformatf("row%0d state", r), 256'(dut_rr.state_q), 256'(tbl[r].st));
      chk($sformatf("row%0d mem_read", r), 256'(rr_mr), 256'(tbl[r].mr));
      chk($sformatf("row%0d mem_write", r), 256'(rr_mw), 256'(tbl[r].mw));
      chk($sformatf("row%0d i_ready", r), 256'(rr_ird), 256'(tbl[r].irdy));
      chk($sformatf("row%0d d_ready", r), 256'(rr_drd), 256'(tbl[r].drdy));
      chk($sformatf("row%0d mem_addr", r), 256'(rr_ma), 256'(ea));
      chk($sformatf("row%0d mem_wdata", r), 256'(rr_mwd), 256'(ew));
      chk($sformatf("row%0d mem_rdata", r), 256'(rr_mrd), 256'(mem_rdata_in));
    end

    @(negedge clk);
    zero_inputs();
    proc_reset = 1;
    @(negedge clk);
    proc_reset = 0; i_mem_read = 1; d_mem_read = 1;
    got = "";
    for (int n = 0; n < 200 && got.len() < 10; n++) begin
      #1;
      st = 2'(dut_dp.state_q);
      if (st != 2'd0) begin
        if (st == 2'd1) begin
          got = {got, "I"};
          chk($sformatf("dp wait_cnt at I grant %0d", got.len()), 256'(dut_dp.wait_cnt_q), 256'd0);
        end else got = {got, "D"};
        mem_ready = 1;
      end
      @(negedge clk);
      mem_ready = 0;
    end
    checks++;
    if (got != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL dp grant order: got %s expected DDDDIDDDDI", got);
    end

    @(negedge clk);
    zero_inputs();
    proc_reset = 1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin own[k] = 0; last[k] = 1; streak[k] = 0; end
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      proc_reset  = ($urandom_range(0, 99) == 0);
      i_mem_read  = ($urandom_range(0, 2) == 0);
      i_mem_write = ($urandom_range(0, 15) == 0);
      d_mem_read  = ($urandom_range(0, 2) == 0);
      d_mem_write = ($urandom_range(0, 3) == 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      i_mem_addr  = 28'($urandom);
      d_mem_addr  = 28'($urandom);
      i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      mem_rdata_in = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk($sformatf("rnd%0d rr outputs", n), {96'd0, rr_mr, rr_mw, rr_ma, rr_mwd, rr_ird, rr_drd}, expv(own[0]));
      chk($sformatf("rnd%0d dp outputs", n), {96'd0, dp_mr, dp_mw, dp_ma, dp_mwd, dp_ird, dp_drd}, expv(own[1]));
      chk($sformatf("rnd%0d dp rdata", n), 256'(dp_mrd), 256'(mem_rdata_in));
      model_step(0);
      model_step(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit main-memory port between the instruction cache (I) and the data cache (D).
- Each cache keeps its existing memory handshake unchanged: it holds read/write, addr and wdata until it sees a one-cycle ready pulse.
- The arbiter registers a grant, forwards the granted cache's request to memory, and routes the memory's ready pulse back to that cache only.
- Sits between the two caches and the memory model at the top level of the pipelined core.

Parameters:
- D_PRIORITY, 1, 1 = D has fixed priority with a starvation guard; 0 = round-robin.
- MAX_WAIT, 4, consecutive D grants allowed while I waits before I is forced (D_PRIORITY=1 only); range 1..15.

Ports:
- clk  in  1  system clock
- proc_reset  in  1  synchronous active-high reset
- i_mem_read  in  1  I-cache read request
- i_mem_write  in  1  I-cache write request (normally 0)
- i_mem_addr  in  28  I-cache block address
- i_mem_wdata  in  128  I-cache write data
- i_mem_ready  out  1  ready pulse to I-cache
- d_mem_read  in  1  D-cache read request
- d_mem_write  in  1  D-cache write-back request
- d_mem_addr  in  28  D-cache block address
- d_mem_wdata  in  128  D-cache write data
- d_mem_ready  out  1  ready pulse to D-cache
- mem_rdata_in  in  128  read data from memory
- mem_ready  in  1  memory completion pulse
- mem_read  out  1  read request to memory
- mem_write  out  1  write request to memory
- mem_addr  out  28  address to memory
- mem_wdata  out  128  write data to memory
- mem_rdata  out  128  mem_rdata_in broadcast to both caches, unregistered

Behaviour:
- Reset: all outputs are 0 except mem_rdata (pass-through); state=IDLE, last_grant=D (so I wins the first round-robin tie), wait_cnt=0.
- Requests: req_i = i_mem_read|i_mem_write; req_d = d_mem_read|d_mem_write.
- States are IDLE, GRANT_I and GRANT_D; the grant is registered.
- IDLE:
  - Memory outputs are all 0.
  - Neither request: stay in IDLE.
  - One request only: go to that grant state.
  - Both, round-robin: grant the master that is not last_grant.
  - Both, D_PRIORITY=1: grant D unless wait_cnt==MAX_WAIT, in which case grant I.
- GRANT_x:
  - mem_read/mem_write/mem_addr/mem_wdata equal master x's inputs combinationally.
  - x_mem_ready = mem_ready; the other master's ready is held at 0.
  - On mem_ready: last_grant<=x and return to IDLE.
  - Otherwise hold the state, even if x drops its request; the arbiter never aborts a memory access.
- Latency: one cycle from request to memory seeing it (the IDLE arbitration cycle), plus the memory latency. There is one IDLE turnaround cycle between back-to-back transactions.
- A D write-back followed by its refill read is two separate transactions; I may be granted between them, which is legal.
- Starvation counter wait_cnt (4 bits):
  - Increments when D is granted from IDLE while req_i=1.
  - Clears when I is granted.
  - Saturates at MAX_WAIT.
  - Unused (held 0) when D_PRIORITY=0.
- mem_ready while in IDLE: ignored; no ready is forwarded to either master.
- Simultaneous read and write from one master: both are forwarded unchanged; the memory defines the result.
- Reset mid-transaction: return to IDLE immediately; the caches are reset in the same cycle.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT_I=2'd1, ST_GRANT_D=2'd2;
  - widths MEM_ADDR_W=28, MEM_DATA_W=128;
  - master IDs M_I=1'b0, M_D=1'b1.
- One natural sub-module, arb_pick: the combinational two-way picker. Inputs are req_i, req_d, last_grant, wait_cnt, D_PRIORITY and MAX_WAIT; outputs are grant_valid and grant_id.
- The state register, counter and muxes stay in mem_arbiter.

Test Plan:
- I read only, memory ready 3 cycles after mem_read rises:
  - mem_read=1 and mem_addr=i_mem_addr=28'h0000010 from cycle 1;
  - i_mem_ready pulses once, d_mem_ready stays 0;
  - state is IDLE the next cycle.
- Both request in the same cycle after reset, D_PRIORITY=0:
  - I granted first;
  - after its ready, D granted with mem_write=1 and mem_wdata=d_mem_wdata=128'hDEADBEEF...;
  - the I/D/I/D order holds while both keep requesting.
- D_PRIORITY=1, MAX_WAIT=4, both continuously requesting:
  - grant order is D,D,D,D,I,D,D,D,D,I;
  - wait_cnt reads 0 after each I grant.
- mem_ready pulsed while IDLE: no x_mem_ready asserted, state unchanged.
- proc_reset asserted during GRANT_D before mem_ready:
  - next cycle state=IDLE and all memory outputs are 0;
  - a later I request is granted first.
- Granted master drops its request mid-transaction:
  - state holds GRANT_x with mem_read=0;
  - returns to IDLE on mem_ready, and the other master is granted next.
